// File: rtl/ram_bist_pkg.sv
// Shared types and constants for the RAM self-test sequencer.
package ram_bist_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 8;

  // pat_sel encodings
  localparam logic [1:0] PAT_DBL  = 2'b00;  // (2*a) mod 2^DATA_W
  localparam logic [1:0] PAT_ADDR = 2'b01;  // a truncated
  localparam logic [1:0] PAT_CHK  = 2'b10;  // a[0] ? AA : 55
  localparam logic [1:0] PAT_INV  = 2'b11;  // ~((2*a) mod 2^DATA_W)

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_CMP,
    ST_DONE
  } state_t;

endpackage

// File: rtl/ram_bist_if.sv
// RAM-side pin bundle: master is the BIST sequencer, slave is the RAM.
interface ram_bist_if
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_wr;
  logic              ram_cs;
  logic [DATA_W-1:0] ram_dout;

  modport master (output ram_addr, ram_din, ram_wr, ram_cs, input ram_dout);
  modport slave  (input ram_addr, ram_din, ram_wr, ram_cs, output ram_dout);
endinterface

// File: rtl/ram_bist_pat.sv
// Combinational test-pattern generator; one instance serves both the write
// and the compare path so the two always regenerate identical data.
module ram_bist_pat
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic [1:0]        pat_sel,
  output logic [DATA_W-1:0] data
);
  logic [DATA_W-1:0] dbl, lin, chk;

  // Build every candidate pattern, then select; all arithmetic truncates to DATA_W.
  always_comb begin
    dbl = DATA_W'({addr, 1'b0});
    lin = DATA_W'(addr);
    chk = '0;
    for (int i = 0; i < DATA_W; i++)
      chk[i] = (addr[0] == ((i % 2) == 1));
    case (pat_sel)
      PAT_DBL:  data = dbl;
      PAT_ADDR: data = lin;
      PAT_CHK:  data = chk;
      default:  data = ~dbl;
    endcase
  end
endmodule

// File: rtl/ram_bist_ctrl.sv
// Fill-and-readback self-test sequencer for a single-port RAM.
// Optional first-mismatch capture ports enabled with RAM_BIST_ERRLOG_EN.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        pat_sel,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W:0]   err_cnt,
`ifdef RAM_BIST_ERRLOG_EN
  output logic              err_vld,
  output logic [ADDR_W-1:0] err_addr,
  output logic [DATA_W-1:0] err_exp,
  output logic [DATA_W-1:0] err_got,
`endif
  ram_bist_if.master        ram
);
  localparam logic [ADDR_W-1:0] K_LAST = '1;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] k, k_nxt;
  logic [1:0]        pat_q, pat_use;
  logic [ADDR_W-1:0] pat_addr;
  logic [DATA_W-1:0] pat_data;
  logic [ADDR_W:0]   err_nxt;
  logic              go, mismatch;

  // A start only counts when idle and not overridden by abort.
  assign go = (state == ST_IDLE) && start && !abort;

  ram_bist_pat #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_pat (
    .addr    (pat_addr),
    .pat_sel (pat_use),
    .data    (pat_data)
  );

  // State, address counter and latched pattern select.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      k     <= '0;
      pat_q <= PAT_DBL;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (go) pat_q <= pat_sel;
    end
  end

  // Next-state and next-address; abort overrides every transition.
  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    if (abort) begin
      state_nxt = ST_IDLE;
      k_nxt     = '0;
    end else begin
      case (state)
        ST_IDLE: begin
          k_nxt = '0;
          if (start) state_nxt = ST_WRITE;
        end
        ST_WRITE: begin
          k_nxt = k + 1'b1;  // wraps to 0 after the last address
          if (k == K_LAST) state_nxt = ST_READ;
        end
        ST_READ: state_nxt = ST_CMP;
        ST_CMP: begin
          if (k == K_LAST) begin
            state_nxt = ST_DONE;
            k_nxt     = '0;
          end else begin
            state_nxt = ST_READ;
            k_nxt     = k + 1'b1;
          end
        end
        default: begin
          state_nxt = ST_IDLE;
          k_nxt     = '0;
        end
      endcase
    end
  end

  // Pattern lookup and compare. Outputs are registered from the next state,
  // so the write path looks up k_nxt while CMP checks the current k. The
  // latched select is not valid yet on the start edge, hence the bypass.
  always_comb begin
    pat_use  = (state == ST_IDLE) ? pat_sel : pat_q;
    pat_addr = (state == ST_CMP) ? k : k_nxt;
    mismatch = (state == ST_CMP) && !abort && (ram.ram_dout != pat_data);
    if (go)            err_nxt = '0;
    else if (mismatch) err_nxt = err_cnt + 1'b1;
    else               err_nxt = err_cnt;
  end

  // Registered status and RAM-side outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy         <= 1'b0;
      done         <= 1'b0;
      pass         <= 1'b0;
      err_cnt      <= '0;
      ram.ram_addr <= '0;
      ram.ram_din  <= '0;
      ram.ram_wr   <= 1'b0;
      ram.ram_cs   <= 1'b0;
    end else begin
      busy         <= (state_nxt == ST_WRITE) || (state_nxt == ST_READ) ||
                      (state_nxt == ST_CMP);
      done         <= (state_nxt == ST_DONE);
      err_cnt      <= err_nxt;
      ram.ram_addr <= k_nxt;
      ram.ram_din  <= (state_nxt == ST_WRITE) ? pat_data : '0;
      ram.ram_wr   <= (state_nxt == ST_WRITE);
      ram.ram_cs   <= (state_nxt == ST_WRITE) || (state_nxt == ST_READ);
      if (abort || go)              pass <= 1'b0;
      else if (state_nxt == ST_DONE) pass <= (err_nxt == '0);
    end
  end

`ifdef RAM_BIST_ERRLOG_EN
  // First mismatch of a run is captured and held until the next start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_vld  <= 1'b0;
      err_addr <= '0;
      err_exp  <= '0;
      err_got  <= '0;
    end else if (go) begin
      err_vld  <= 1'b0;
    end else if (mismatch && !err_vld) begin
      err_vld  <= 1'b1;
      err_addr <= k;
      err_exp  <= pat_data;
      err_got  <= ram.ram_dout;
    end
  end
`endif
endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench: behavioural RAM with fault injection, expected
// completions queued at start and checked when done pulses.
module tb_ram_bist_ctrl;
  import ram_bist_pkg::*;

  localparam int AW    = 10;
  localparam int DW    = 8;
  localparam int DEPTH = 1 << AW;
  localparam int RUN   = 3 * DEPTH + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [1:0]    pat_sel = PAT_DBL;
  logic          busy, done, pass;
  logic [AW:0]   err_cnt;
`ifdef RAM_BIST_ERRLOG_EN
  logic          err_vld;
  logic [AW-1:0] err_addr;
  logic [DW-1:0] err_exp, err_got;
`endif

  ram_bist_if #(.ADDR_W(AW), .DATA_W(DW)) ram ();

  ram_bist_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .pat_sel  (pat_sel),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .err_cnt  (err_cnt),
`ifdef RAM_BIST_ERRLOG_EN
    .err_vld  (err_vld),
    .err_addr (err_addr),
    .err_exp  (err_exp),
    .err_got  (err_got),
`endif
    .ram      (ram)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM model: stuck-at-1 mask and single-address corruption on reads.
  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] stuck_or = '0;
  logic          corrupt_en = 1'b0;
  logic [AW-1:0] corrupt_a = '0;
  always @(posedge clk)
    if (ram.ram_cs) begin
      if (ram.ram_wr) mem[ram.ram_addr] <= ram.ram_din;
      else ram.ram_dout <= (mem[ram.ram_addr] | stuck_or) ^
                           ((corrupt_en && ram.ram_addr == corrupt_a) ? 8'h01 : 8'h00);
    end

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  typedef struct {
    int            cyc;
    logic          pass;
    logic [AW:0]   err;
    logic [AW-1:0] ea;
    logic [DW-1:0] ee, eg;
  } exp_t;
  exp_t q[$];

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && done) begin
      chk("done_expected", q.size(), 1);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("done_cycle", cyc, e.cyc);
        chk("pass", pass, e.pass);
        chk("err_cnt", err_cnt, e.err);
        chk("busy_at_done", busy, 0);
`ifdef RAM_BIST_ERRLOG_EN
        chk("err_vld", err_vld, e.err != 0);
        if (e.err != 0) begin
          chk("err_addr", err_addr, e.ea);
          chk("err_exp", err_exp, e.ee);
          chk("err_got", err_got, e.eg);
        end
`endif
      end
    end
  end

  // Pulse start; optionally queue the completion. Returns in cycle 1.
  task automatic run(input logic [1:0] ps, input bit push, input logic p,
                     input int err, input int ea, input int ee, input int eg,
                     input logic [7:0] din0);
    exp_t e;
    @(negedge clk);
    pat_sel = ps;
    start   = 1'b1;
    if (push) begin
      e.cyc = cyc + RUN; e.pass = p; e.err = err[AW:0];
      e.ea = ea[AW-1:0]; e.ee = ee[DW-1:0]; e.eg = eg[DW-1:0];
      q.push_back(e);
    end
    @(negedge clk);
    start = 1'b0;
    chk("c1_busy", busy, 1);
    chk("c1_cs_wr", {ram.ram_cs, ram.ram_wr}, 2'b11);
    chk("c1_addr", ram.ram_addr, 0);
    chk("c1_din", ram.ram_din, din0);
  endtask

  task automatic wait_done();
    bit seen = 0;
    for (int i = 0; i < RUN + 10 && !seen; i++) begin
      @(negedge clk);
      seen = done;
    end
    chk("done_seen", seen, 1);
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_pass", pass, 0);
    chk("rst_err", err_cnt, 0);
    chk("rst_addr", ram.ram_addr, 0);
    chk("rst_din", ram.ram_din, 0);
    chk("rst_cs_wr", {ram.ram_cs, ram.ram_wr}, 0);
    rst_n = 1'b1;

    // Clean run, pattern 00
    run(PAT_DBL, 1, 1, 0, 0, 0, 0, 8'h00);
    wait_done();
    chk("mem5_p00", mem[5], 8'd10);
    chk("mem1023_p00", mem[1023], 8'd254);
    chk("pass_held", pass, 1);

    // Data bit 0 stuck at 1: every compare fails
    stuck_or = 8'h01;
    run(PAT_DBL, 1, 0, 1024, 0, 8'h00, 8'h01, 8'h00);
    wait_done();
    stuck_or = 8'h00;

    // Single corrupted location, pattern 01
    corrupt_en = 1'b1; corrupt_a = 10'd700;
    run(PAT_ADDR, 1, 0, 1, 700, 8'hBC, 8'hBD, 8'h00);
    wait_done();
    corrupt_en = 1'b0;

    // Abort during WRITE at cycle 500
    run(PAT_CHK, 0, 0, 0, 0, 0, 0, 8'h55);
    repeat (499) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_cs", ram.ram_cs, 0);
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_pass", pass, 0);

    // Abort during READ/CMP keeps the partial count (k=0,1 compared)
    stuck_or = 8'h01;
    run(PAT_DBL, 0, 0, 0, 0, 0, 0, 8'h00);
    repeat (1028) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    stuck_or = 8'h00;
    chk("abort_partial_err", err_cnt, 2);
    chk("abort2_busy", busy, 0);

    // start and abort together in IDLE: nothing starts
    @(negedge clk);
    start = 1'b1; abort = 1'b1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_cs", ram.ram_cs, 0);

    // Full run after abort, pattern 10
    run(PAT_CHK, 1, 1, 0, 0, 0, 0, 8'h55);
    wait_done();
    chk("mem3_p10", mem[3], 8'hAA);
    chk("mem4_p10", mem[4], 8'h55);

    // Pattern 11; start and pat_sel change mid-run are ignored
    run(PAT_INV, 1, 1, 0, 0, 0, 0, 8'hFF);
    repeat (1499) @(negedge clk);
    start = 1'b1; pat_sel = PAT_DBL;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    chk("mem5_p11", mem[5], 8'hF5);
    chk("mem1023_p11", mem[1023], 8'h01);

    // Reset mid READ/CMP: outputs clear without a clock edge
    run(PAT_DBL, 0, 0, 0, 0, 0, 0, 8'h00);
    repeat (1999) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_cs", ram.ram_cs, 0);
    chk("mid_rst_err", err_cnt, 0);
    chk("mid_rst_addr", ram.ram_addr, 0);
    @(negedge clk);
    rst_n = 1'b1;
    run(PAT_DBL, 1, 1, 0, 0, 0, 0, 8'h00);
    wait_done();

    chk("pending_done", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

Self-test sequencer that sits directly upstream of the 1024x8 single-port RAM and drives its address, data, write and chip-select pins. On a start pulse it writes a selectable data pattern to every address, then reads every address back and compares it against the regenerated pattern. It reports an error count and a pass/fail result. It runs the same fill-and-readback check the RAM bench performs, as synthesizable RTL for in-system test.

## Interface
Parameters:
- ADDR_W, 10, RAM address width; DEPTH = 2**ADDR_W
- DATA_W, 8, RAM data width

Ports:
- clk  in  1  single clock; all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; sampled only in IDLE
- abort  in  1  synchronous; returns to IDLE from any state
- pat_sel  in  2  pattern: 00 = (2*a) mod 2^DATA_W, 01 = a[DATA_W-1:0], 10 = a[0] ? 8'hAA : 8'h55, 11 = ~((2*a) mod 2^DATA_W)
- busy  out  1  high while the test runs
- done  out  1  one-cycle pulse at completion (not on abort)
- pass  out  1  valid from done; held until next start
- err_cnt  out  ADDR_W+1  mismatch count; holds 0..DEPTH
- ram_addr  out  ADDR_W  RAM address
- ram_din  out  DATA_W  RAM write data
- ram_wr  out  1  1 = write, 0 = read
- ram_cs  out  1  chip select, active-high
- ram_dout  in  DATA_W  RAM read data; valid the cycle after a read is issued

## Operation
- States: IDLE, WRITE, READ, CMP, DONE.
- IDLE: ram_cs=0, busy=0. When start=1, latch pat_sel, clear err_cnt and pass, set k=0, and go to WRITE.
- WRITE: ram_cs=1, ram_wr=1, ram_addr=k, ram_din=pat(k). k increments each cycle. At k=DEPTH-1, wrap k to 0 and go to READ.
- READ: ram_cs=1, ram_wr=0, ram_addr=k. Go to CMP.
- CMP: ram_cs=0. Compare ram_dout with pat(k). On mismatch, err_cnt+1.
  - If k=DEPTH-1, go to DONE.
  - Otherwise k+1 and go to READ.
- DONE: done=1 and pass=(err_cnt==0) for one cycle, then IDLE.
- Pattern arithmetic is truncated to DATA_W bits. Example: a=1023 with pat 00 gives 254.
- err_cnt cannot overflow: its maximum is DEPTH, which fits in ADDR_W+1 bits.
- start while busy is ignored.
- abort has priority over all transitions. Next cycle: IDLE, ram_cs=0, no done, pass=0, err_cnt keeps its partial value.
- start and abort asserted together in IDLE: abort wins and the test does not start.
- pat_sel changes mid-test have no effect.

## Timing
- Reset values: busy=0, done=0, pass=0, err_cnt=0, ram_addr=0, ram_din=0, ram_wr=0, ram_cs=0. State is IDLE.
- All RAM-side outputs are registered.
- Cycle numbering: start is sampled at edge 0.
  - WRITE occupies cycles 1..DEPTH.
  - READ/CMP pairs occupy cycles DEPTH+1..3*DEPTH.
  - DONE is cycle 3*DEPTH+1 (3073 at default).
- busy is high in cycles 1..3*DEPTH and low in the done cycle.
- A new start is accepted in the cycle after done.
- Reset mid-run returns immediately to reset values. ram_cs deasserts asynchronously.

## Configuration
- RAM_BIST_ERRLOG_EN defined: adds outputs err_vld (1), err_addr (ADDR_W), err_exp (DATA_W), err_got (DATA_W).
  - These capture the first mismatch of a run.
  - err_vld stays set until the next start or reset.
  - Later mismatches do not overwrite the capture.
- Macro undefined: those ports and registers are absent. Remaining behaviour is identical.

## Structure
- Package ram_bist_pkg holds:
  - the state enum
  - the pat_sel encodings
  - default ADDR_W/DATA_W constants
- Sub-module ram_bist_pat: combinational pattern generator (address, pat_sel -> data). It is shared by the write path and the compare path so both regenerate identical values.

## Test plan
- Fault-free RAM model, pat 00: done at cycle 3073, pass=1, err_cnt=0. Address 5 holds 10; address 1023 holds 254.
- RAM model with data bit 0 stuck at 1, pat 00: err_cnt=1024, pass=0. With ERRLOG: err_addr=0, err_exp=0x00, err_got=0x01.
- Corrupt address 700 between phases, pat 01: err_cnt=1, pass=0, err_addr=700, err_exp=0xBC.
- abort at cycle 500 (WRITE): ram_cs=0 and busy=0 next cycle, no done pulse, pass=0. A following start runs a full test.
- start pulsed at cycle 1500: ignored, done still at cycle 3073.
- rst_n low at cycle 2000 (READ/CMP): all outputs 0 immediately. After release, start gives a clean pass.
